// File: rtl/qbert_sysid_checker.sv
// Boot-time image check: reads the system-ID slave (ID word, then timestamp),
// compares both against build-time constants and publishes registered flags.
module qbert_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd34,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1459253078,
    parameter int unsigned TIMEOUT_CYCLES     = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic        m_readdatavalid,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        BOOT,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        DONE
    } state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_count;
    logic        in_wait;
    logic        expired;

    assign in_wait = (state == ID_WAIT) || (state == TS_WAIT);
    // Valid in the final wait cycle takes priority over the abort.
    assign expired = in_wait && !m_readdatavalid && (wait_count == LAST_WAIT);

    assign m_read    = (state == ID_REQ) || (state == TS_REQ);
    assign m_address = (state == TS_REQ);
    assign busy      = (state != DONE);
    assign done      = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = ID_REQ;
            ID_REQ:  if (!m_waitrequest) state_next = ID_WAIT;
            ID_WAIT: begin
                if (m_readdatavalid) begin
                    state_next = TS_REQ;
                end else if (expired) begin
                    state_next = DONE;
                end
            end
            TS_REQ:  if (!m_waitrequest) state_next = TS_WAIT;
            TS_WAIT: if (m_readdatavalid || expired) state_next = DONE;
            DONE:    if (start) state_next = ID_REQ;
            default: state_next = BOOT;
        endcase
    end

    // Response watchdog: only runs while a read is outstanding.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_count <= '0;
        end else if (m_read && !m_waitrequest) begin
            wait_count <= '0;
        end else if (in_wait && !m_readdatavalid) begin
            wait_count <= wait_count + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= '0;
            ts_value <= '0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (state == ID_WAIT && m_readdatavalid) begin
                id_value <= m_readdata;
                id_match <= (m_readdata == EXPECTED_ID);
            end
            if (state == TS_WAIT && m_readdatavalid) begin
                ts_value <= m_readdata;
                ts_match <= (m_readdata == EXPECTED_TIMESTAMP);
            end
            if (expired) begin
                timeout <= 1'b1;
            end
            if (state == DONE && start) begin
                id_value <= '0;
                ts_value <= '0;
                id_match <= 1'b0;
                ts_match <= 1'b0;
                timeout  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qbert_sysid_checker.sv
// Self-checking bench for qbert_sysid_checker: behavioural Avalon slave,
// directed vector table, hand sequences and randomized runs against a model.
module tb_qbert_sysid_checker;

    localparam int          T      = 16;
    localparam logic [31:0] EXP_ID = 32'd34;
    localparam logic [31:0] EXP_TS = 32'd1459253078;

    typedef struct {
        int          w_id;
        int          w_ts;
        int          d_id;
        int          d_ts;
        bit          id_resp;
        bit          ts_resp;
        logic [31:0] id_data;
        logic [31:0] ts_data;
        int          start_edge;
    } cfg_t;

    typedef struct {
        int          done_edge;
        bit          id_match;
        bit          ts_match;
        bit          timeout;
        logic [31:0] id_value;
        logic [31:0] ts_value;
        int          ts_acc;
    } exp_t;

    typedef struct {
        cfg_t c;
        exp_t e;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic        m_readdatavalid;
    logic [31:0] m_readdata;
    logic        busy;
    logic        done;
    logic        id_match;
    logic        ts_match;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int checks = 0;
    int errors = 0;

    int          wait_cfg[2];
    int          delay_cfg[2];
    bit          resp_cfg[2];
    logic [31:0] data_cfg[2];
    int          acc[2];
    int          first_addr;
    bit          in_req;
    int          req_addr;
    int          wait_left;
    int          pend_cnt;
    logic [31:0] pend_data;
    bit          inject;
    logic [31:0] inject_data;

    qbert_sysid_checker #(
        .EXPECTED_ID       (EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_waitrequest  (m_waitrequest),
        .m_readdatavalid(m_readdatavalid),
        .m_readdata     (m_readdata),
        .busy           (busy),
        .done           (done),
        .id_match       (id_match),
        .ts_match       (ts_match),
        .timeout        (timeout),
        .id_value       (id_value),
        .ts_value       (ts_value)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Slave acts on the falling edge so its outputs are settled for the next rising edge.
    initial begin
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        in_req = 0; pend_cnt = 0; inject = 0; first_addr = -1;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                in_req = 0; pend_cnt = 0; inject = 0;
                m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
            end else begin
                m_readdatavalid = 1'b0;
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        m_readdatavalid = 1'b1;
                        m_readdata      = pend_data;
                    end
                end
                if (inject) begin
                    inject = 0;
                    m_readdatavalid = 1'b1;
                    m_readdata      = inject_data;
                end
                if (m_read) begin
                    if (!in_req) begin
                        in_req    = 1;
                        req_addr  = int'(m_address);
                        wait_left = wait_cfg[m_address];
                    end else begin
                        checkOutput("addr_hold", 32'(m_address), req_addr[31:0]);
                    end
                    if (wait_left > 0) begin
                        m_waitrequest = 1'b1;
                        wait_left--;
                    end else begin
                        m_waitrequest = 1'b0;
                        in_req = 0;
                        acc[m_address]++;
                        if (first_addr < 0) first_addr = int'(m_address);
                        if (resp_cfg[m_address]) begin
                            pend_cnt  = delay_cfg[m_address];
                            pend_data = data_cfg[m_address];
                        end
                    end
                end else begin
                    if (in_req) begin
                        checkOutput("read_hold", 32'(m_read), 32'd1);
                        in_req = 0;
                    end
                    m_waitrequest = 1'b0;
                end
            end
        end
    end

    function automatic cfg_t mkCfg(int w_id, int w_ts, int d_id, int d_ts, bit id_resp, bit ts_resp,
                                   logic [31:0] id_data, logic [31:0] ts_data, int start_edge);
        cfg_t c;
        c.w_id = w_id; c.w_ts = w_ts; c.d_id = d_id; c.d_ts = d_ts;
        c.id_resp = id_resp; c.ts_resp = ts_resp;
        c.id_data = id_data; c.ts_data = ts_data; c.start_edge = start_edge;
        return c;
    endfunction

    function automatic exp_t mkExp(int done_edge, bit idm, bit tsm, bit to,
                                   logic [31:0] idv, logic [31:0] tsv, int ts_acc);
        exp_t e;
        e.done_edge = done_edge; e.id_match = idm; e.ts_match = tsm; e.timeout = to;
        e.id_value = idv; e.ts_value = tsv; e.ts_acc = ts_acc;
        return e;
    endfunction

    // Reference: a read times out when its response lands later than T wait cycles.
    function automatic exp_t model(cfg_t c);
        exp_t e;
        int   base;
        e = mkExp(0, 0, 0, 0, 0, 0, 0);
        if (!c.id_resp || c.d_id > T) begin
            e.done_edge = 2 + c.w_id + T;
            e.timeout   = 1;
        end else begin
            e.id_value = c.id_data;
            e.id_match = (c.id_data == EXP_ID);
            e.ts_acc   = 1;
            base = 3 + c.w_id + c.d_id + c.w_ts;
            if (!c.ts_resp || c.d_ts > T) begin
                e.done_edge = base + T;
                e.timeout   = 1;
            end else begin
                e.done_edge = base + c.d_ts;
                e.ts_value  = c.ts_data;
                e.ts_match  = (c.ts_data == EXP_TS);
            end
        end
        return e;
    endfunction

    task automatic checkResetValues(input string name);
        checkOutput({name, ":m_read"},    32'(m_read),    32'd0);
        checkOutput({name, ":m_address"}, 32'(m_address), 32'd0);
        checkOutput({name, ":busy"},      32'(busy),      32'd1);
        checkOutput({name, ":done"},      32'(done),      32'd0);
        checkOutput({name, ":id_match"},  32'(id_match),  32'd0);
        checkOutput({name, ":ts_match"},  32'(ts_match),  32'd0);
        checkOutput({name, ":timeout"},   32'(timeout),   32'd0);
        checkOutput({name, ":id_value"},  id_value,       32'd0);
        checkOutput({name, ":ts_value"},  ts_value,       32'd0);
    endtask

    task automatic loadSlave(input cfg_t c);
        wait_cfg[0] = c.w_id;     wait_cfg[1] = c.w_ts;
        delay_cfg[0] = c.d_id;    delay_cfg[1] = c.d_ts;
        resp_cfg[0] = c.id_resp;  resp_cfg[1] = c.ts_resp;
        data_cfg[0] = c.id_data;  data_cfg[1] = c.ts_data;
        acc[0] = 0; acc[1] = 0; first_addr = -1;
    endtask

    task automatic applyStimulus(input cfg_t c, input string name);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        start   = 1'b0;
        loadSlave(c);
        #1 checkResetValues(name);
        @(negedge clock);
        #1 reset_n = 1'b1;
    endtask

    // Counts rising edges until done, optionally pulsing start while still busy.
    task automatic waitDone(input int start_edge, output int n);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clock);
            #1;
            n++;
            if (start) start = 1'b0;
            if (!done && start_edge == n) start = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic checkResults(input string name, input int n, input exp_t e);
        checkOutput({name, ":done"},      32'(done),     32'd1);
        checkOutput({name, ":done_edge"}, n,             e.done_edge);
        checkOutput({name, ":busy"},      32'(busy),     32'd0);
        checkOutput({name, ":id_match"},  32'(id_match), 32'(e.id_match));
        checkOutput({name, ":ts_match"},  32'(ts_match), 32'(e.ts_match));
        checkOutput({name, ":timeout"},   32'(timeout),  32'(e.timeout));
        checkOutput({name, ":id_value"},  id_value,      e.id_value);
        checkOutput({name, ":ts_value"},  ts_value,      e.ts_value);
        checkOutput({name, ":id_reads"},  acc[0],        32'd1);
        checkOutput({name, ":ts_reads"},  acc[1],        e.ts_acc);
        checkOutput({name, ":first_addr"}, first_addr,   32'd0);
    endtask

    task automatic runAndCheck(input string name, input cfg_t c, input exp_t e);
        int n;
        applyStimulus(c, name);
        waitDone(c.start_edge, n);
        checkResults(name, n, e);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=%0d expected=%0d", checks, 0);
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        vec_t tbl[9];
        cfg_t nominal;
        cfg_t c;
        int   n;

        nominal = mkCfg(0, 0, 1, 1, 1, 1, EXP_ID, EXP_TS, 0);
        tbl[0] = '{nominal,                                        mkExp(5,  1, 1, 0, EXP_ID, EXP_TS, 1)};
        tbl[1] = '{mkCfg(3, 0, 1, 1, 1, 1, EXP_ID, EXP_TS, 0),     mkExp(8,  1, 1, 0, EXP_ID, EXP_TS, 1)};
        tbl[2] = '{mkCfg(0, 0, 1, 1, 1, 1, EXP_ID, 32'd1459253079, 0),
                                                                   mkExp(5,  1, 0, 0, EXP_ID, 32'd1459253079, 1)};
        tbl[3] = '{mkCfg(0, 0, 1, 1, 0, 1, EXP_ID, EXP_TS, 0),     mkExp(18, 0, 0, 1, 0, 0, 0)};
        tbl[4] = '{mkCfg(0, 0, 16, 1, 1, 1, EXP_ID, EXP_TS, 0),    mkExp(20, 1, 1, 0, EXP_ID, EXP_TS, 1)};
        tbl[5] = '{mkCfg(0, 2, 1, 1, 1, 0, EXP_ID, EXP_TS, 0),     mkExp(22, 1, 0, 1, EXP_ID, 0, 1)};
        tbl[6] = '{mkCfg(0, 0, 17, 1, 1, 1, EXP_ID, EXP_TS, 0),    mkExp(18, 0, 0, 1, 0, 0, 0)};
        tbl[7] = '{mkCfg(0, 0, 1, 1, 1, 1, 32'd35, EXP_TS, 2),     mkExp(5,  0, 1, 0, 32'd35, EXP_TS, 1)};
        tbl[8] = '{mkCfg(0, 1, 1, 3, 1, 1, EXP_ID, EXP_TS, 3),     mkExp(8,  1, 1, 0, EXP_ID, EXP_TS, 1)};

        for (int i = 0; i < 9; i++) begin
            runAndCheck($sformatf("vec%0d", i), tbl[i].c, tbl[i].e);
        end

        // Late response after an ID timeout must not disturb the published results.
        runAndCheck("late", tbl[3].c, tbl[3].e);
        inject_data = EXP_ID;
        inject = 1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checkOutput("late:done",     32'(done),     32'd1);
        checkOutput("late:timeout",  32'(timeout),  32'd1);
        checkOutput("late:id_match", 32'(id_match), 32'd0);
        checkOutput("late:id_value", id_value,      32'd0);
        checkOutput("late:ts_reads", acc[1],        32'd0);

        // Start in DONE clears results on the same edge and reruns the whole check.
        runAndCheck("first", nominal, tbl[0].e);
        acc[0] = 0; acc[1] = 0; first_addr = -1;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        checkOutput("restart:done",     32'(done),     32'd0);
        checkOutput("restart:busy",     32'(busy),     32'd1);
        checkOutput("restart:id_match", 32'(id_match), 32'd0);
        checkOutput("restart:ts_match", 32'(ts_match), 32'd0);
        checkOutput("restart:id_value", id_value,      32'd0);
        checkOutput("restart:ts_value", ts_value,      32'd0);
        n = 1;
        while (!done && n < 300) begin
            @(posedge clock);
            #1 n++;
        end
        checkResults("restart", n, tbl[0].e);

        // Reset pulsed while the timestamp response is still outstanding.
        c = nominal;
        c.d_ts = 10;
        applyStimulus(c, "midrun_pre");
        repeat (5) @(posedge clock);
        #3 reset_n = 1'b0;
        #1 checkResetValues("midrun");
        loadSlave(nominal);
        @(negedge clock);
        #1 reset_n = 1'b1;
        waitDone(0, n);
        checkResults("midrun", n, tbl[0].e);

        // Randomized runs scored against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            c.w_id       = $urandom_range(0, 3);
            c.w_ts       = $urandom_range(0, 3);
            c.d_id       = $urandom_range(1, T + 3);
            c.d_ts       = $urandom_range(1, T + 3);
            c.id_resp    = ($urandom_range(0, 7) != 0);
            c.ts_resp    = ($urandom_range(0, 7) != 0);
            c.id_data    = $urandom_range(0, 1) ? EXP_ID : $urandom;
            c.ts_data    = $urandom_range(0, 1) ? EXP_TS : $urandom;
            c.start_edge = $urandom_range(0, 4);
            runAndCheck($sformatf("rand%0d", i), c, model(c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
